// File: rtl/countdown_pkg.sv
// Shared types and digit limits for the MM:SS countdown timer.
package countdown_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      PAUSE = 2'd2,
      DONE  = 2'd3
   } cd_state_t;

   // Largest value a BCD units digit may hold.
   localparam int UNITS_MAX = 9;
   // Largest value a tens digit may hold (minutes and seconds).
   localparam int TENS_MAX  = 5;

endpackage

// File: rtl/down_digit.sv
// One decimal digit of the countdown: clamped load, decrement with wrap to MAX,
// and a borrow strobe that feeds the next more significant digit.
module down_digit #(
   parameter int W   = 4,
   parameter int MAX = 9
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         load,
   input  logic [W-1:0] load_val,
   input  logic         dec,
   output logic [W-1:0] q,
   output logic         borrow_out
);

   localparam logic [W-1:0] MAX_V = W'(MAX);

   // Digit register: a load (clamped to MAX) wins over a decrement; 0 wraps to MAX.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         q <= '0;
      end else if (load) begin
         q <= (load_val > MAX_V) ? MAX_V : load_val;
      end else if (dec) begin
         q <= (q == '0) ? MAX_V : (q - W'(1));
      end else begin
         q <= q;
      end
   end

   assign borrow_out = dec && (q == '0);

endmodule

// File: rtl/countdown_timer.sv
// Loadable MM:SS countdown timer with pause/resume, expiry flag and optional
// auto-reload of the last loaded preset.
module countdown_timer
   import countdown_pkg::*;
#(
   parameter bit AUTO_RELOAD = 1'b0
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       tick,
   input  logic       load,
   input  logic [2:0] load_min_tens,
   input  logic [3:0] load_min_units,
   input  logic [2:0] load_sec_tens,
   input  logic [3:0] load_sec_units,
   input  logic       start,
   input  logic       pause,
   output logic [2:0] min_tens,
   output logic [3:0] min_units,
   output logic [2:0] sec_tens,
   output logic [3:0] sec_units,
   output logic       running,
   output logic       expired,
   output logic       done_pulse
);

   cd_state_t  state_r, nxt_state_s;
   logic       running_r, expired_r, done_pulse_r;
   logic [2:0] pre_mt_r, pre_st_r;
   logic [3:0] pre_mu_r, pre_su_r;

   logic       dig_load_s, use_user_s, dec_s, pulse_s;
   logic       su_borrow_s, st_borrow_s, mu_borrow_s, mt_borrow_s;
   logic       count_zero_s, count_one_s, preset_zero_s;
   logic [2:0] ld_mt_s, ld_st_s;
   logic [3:0] ld_mu_s, ld_su_s;

   assign count_zero_s  = (min_tens == 3'd0) && (min_units == 4'd0) &&
                          (sec_tens == 3'd0) && (sec_units == 4'd0);
   assign count_one_s   = (min_tens == 3'd0) && (min_units == 4'd0) &&
                          (sec_tens == 3'd0) && (sec_units == 4'd1);
   assign preset_zero_s = (pre_mt_r == 3'd0) && (pre_mu_r == 4'd0) &&
                          (pre_st_r == 3'd0) && (pre_su_r == 4'd0);

   // Digits take the user inputs on an accepted load, otherwise the stored preset.
   assign ld_mt_s = use_user_s ? load_min_tens  : pre_mt_r;
   assign ld_mu_s = use_user_s ? load_min_units : pre_mu_r;
   assign ld_st_s = use_user_s ? load_sec_tens  : pre_st_r;
   assign ld_su_s = use_user_s ? load_sec_units : pre_su_r;

   // Next-state and datapath control; priority load > pause > start > tick.
   always_comb begin
      nxt_state_s = state_r;
      dig_load_s  = 1'b0;
      use_user_s  = 1'b0;
      dec_s       = 1'b0;
      pulse_s     = 1'b0;
      case (state_r)
         IDLE, PAUSE: begin
            if (load) begin
               dig_load_s  = 1'b1;
               use_user_s  = 1'b1;
               nxt_state_s = IDLE;
            end else if (pause) begin
               nxt_state_s = state_r;
            end else if (start) begin
               if ((state_r == IDLE) && count_zero_s) begin
                  nxt_state_s = DONE;
                  pulse_s     = 1'b1;
               end else begin
                  nxt_state_s = RUN;
               end
            end else begin
               nxt_state_s = state_r;
            end
         end
         RUN: begin
            if (pause) begin
               nxt_state_s = PAUSE;
            end else if (tick) begin
               if (count_zero_s) begin
                  // Only reachable with auto-reload: 00:00 was shown for one tick.
                  if (preset_zero_s) begin
                     nxt_state_s = DONE;
                  end else begin
                     dig_load_s  = 1'b1;
                     nxt_state_s = RUN;
                  end
               end else begin
                  dec_s = 1'b1;
                  if (count_one_s) begin
                     pulse_s = 1'b1;
                     if (AUTO_RELOAD) begin
                        nxt_state_s = RUN;
                     end else begin
                        nxt_state_s = DONE;
                     end
                  end else begin
                     nxt_state_s = RUN;
                  end
               end
            end else begin
               nxt_state_s = RUN;
            end
         end
         DONE: begin
            if (load) begin
               dig_load_s  = 1'b1;
               use_user_s  = 1'b1;
               nxt_state_s = IDLE;
            end else begin
               nxt_state_s = DONE;
            end
         end
         default: begin
            nxt_state_s = IDLE;
         end
      endcase
   end

   // State, registered status outputs and the preset captured on a user load.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_r      <= IDLE;
         running_r    <= 1'b0;
         expired_r    <= 1'b0;
         done_pulse_r <= 1'b0;
         pre_mt_r     <= 3'd0;
         pre_mu_r     <= 4'd0;
         pre_st_r     <= 3'd0;
         pre_su_r     <= 4'd0;
      end else begin
         if (mt_borrow_s) begin
            // A borrow out of the top digit means the count underflowed; stop there.
            state_r   <= DONE;
            running_r <= 1'b0;
            expired_r <= 1'b1;
         end else begin
            state_r   <= nxt_state_s;
            running_r <= (nxt_state_s == RUN);
            expired_r <= (nxt_state_s == DONE);
         end
         done_pulse_r <= pulse_s;
         if (dig_load_s && use_user_s) begin
            pre_mt_r <= load_min_tens;
            pre_mu_r <= load_min_units;
            pre_st_r <= load_sec_tens;
            pre_su_r <= load_sec_units;
         end else begin
            pre_mt_r <= pre_mt_r;
            pre_mu_r <= pre_mu_r;
            pre_st_r <= pre_st_r;
            pre_su_r <= pre_su_r;
         end
      end
   end

   assign running    = running_r;
   assign expired    = expired_r;
   assign done_pulse = done_pulse_r;

   down_digit #(.W(4), .MAX(UNITS_MAX)) u_sec_units (
      .clk(clk), .reset(reset), .load(dig_load_s), .load_val(ld_su_s),
      .dec(dec_s), .q(sec_units), .borrow_out(su_borrow_s)
   );

   down_digit #(.W(3), .MAX(TENS_MAX)) u_sec_tens (
      .clk(clk), .reset(reset), .load(dig_load_s), .load_val(ld_st_s),
      .dec(su_borrow_s), .q(sec_tens), .borrow_out(st_borrow_s)
   );

   down_digit #(.W(4), .MAX(UNITS_MAX)) u_min_units (
      .clk(clk), .reset(reset), .load(dig_load_s), .load_val(ld_mu_s),
      .dec(st_borrow_s), .q(min_units), .borrow_out(mu_borrow_s)
   );

   down_digit #(.W(3), .MAX(TENS_MAX)) u_min_tens (
      .clk(clk), .reset(reset), .load(dig_load_s), .load_val(ld_mt_s),
      .dec(mu_borrow_s), .q(min_tens), .borrow_out(mt_borrow_s)
   );

endmodule

// File: tb/tb_countdown_timer.sv
// Table-driven bench for countdown_timer; one instance without and one with
// auto-reload share the stimulus, each table row names which one it checks.
module tb_countdown_timer;

   logic       clk, reset, tick, load, start, pause;
   logic [2:0] load_min_tens, load_sec_tens;
   logic [3:0] load_min_units, load_sec_units;
   logic [2:0] mt0, st0, mt1, st1;
   logic [3:0] mu0, su0, mu1, su1;
   logic       run0, exp0, dp0, run1, exp1, dp1;

   typedef struct {
      logic        sel;
      logic        ld;
      logic [2:0]  lmt;
      logic [3:0]  lmu;
      logic [2:0]  lst;
      logic [3:0]  lsu;
      logic        st, pa, tk;
      logic [16:0] exp;
   } vec_t;

   typedef struct {
      logic        sel;
      logic [16:0] exp;
      int          idx;
   } sb_t;

   vec_t vecs[$];
   sb_t  sb[$];
   int   n_pass   = 0;
   int   n_checks = 0;
   int   base     = 0;

   countdown_timer #(.AUTO_RELOAD(1'b0)) dut0 (
      .clk(clk), .reset(reset), .tick(tick), .load(load),
      .load_min_tens(load_min_tens), .load_min_units(load_min_units),
      .load_sec_tens(load_sec_tens), .load_sec_units(load_sec_units),
      .start(start), .pause(pause),
      .min_tens(mt0), .min_units(mu0), .sec_tens(st0), .sec_units(su0),
      .running(run0), .expired(exp0), .done_pulse(dp0)
   );

   countdown_timer #(.AUTO_RELOAD(1'b1)) dut1 (
      .clk(clk), .reset(reset), .tick(tick), .load(load),
      .load_min_tens(load_min_tens), .load_min_units(load_min_units),
      .load_sec_tens(load_sec_tens), .load_sec_units(load_sec_units),
      .start(start), .pause(pause),
      .min_tens(mt1), .min_units(mu1), .sec_tens(st1), .sec_units(su1),
      .running(run1), .expired(exp1), .done_pulse(dp1)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   function automatic logic [16:0] outs(input logic sel);
      if (sel) return {mt1, mu1, st1, su1, run1, exp1, dp1};
      else     return {mt0, mu0, st0, su0, run0, exp0, dp0};
   endfunction

   function automatic string fmt(input logic [16:0] v);
      return $sformatf("%0d%0d:%0d%0d run=%0b exp=%0b dp=%0b",
                       v[16:14], v[13:10], v[9:7], v[6:3], v[2], v[1], v[0]);
   endfunction

   task automatic check(input string name, input logic [16:0] act, input logic [16:0] req);
      n_checks++;
      if (act === req) n_pass++;
      else $display("FAIL %s: got %s, want %s", name, fmt(act), fmt(req));
   endtask

   function automatic void add(input logic sel, input logic ld,
                               input int lmt, input int lmu, input int lst, input int lsu,
                               input logic st, input logic pa, input logic tk,
                               input int emt, input int emu, input int est, input int esu,
                               input logic er, input logic ee, input logic ed);
      vec_t v;
      v.sel = sel; v.ld = ld;
      v.lmt = 3'(lmt); v.lmu = 4'(lmu); v.lst = 3'(lst); v.lsu = 4'(lsu);
      v.st = st; v.pa = pa; v.tk = tk;
      v.exp = {3'(emt), 4'(emu), 3'(est), 4'(esu), er, ee, ed};
      vecs.push_back(v);
   endfunction

   // Drive each row for one cycle, queue its expectation, compare after the edge.
   task automatic run_vecs();
      sb_t e;
      for (int i = 0; i < vecs.size(); i++) begin
         load = vecs[i].ld;
         load_min_tens = vecs[i].lmt; load_min_units = vecs[i].lmu;
         load_sec_tens = vecs[i].lst; load_sec_units = vecs[i].lsu;
         start = vecs[i].st; pause = vecs[i].pa; tick = vecs[i].tk;
         e.sel = vecs[i].sel; e.exp = vecs[i].exp; e.idx = base + i;
         sb.push_back(e);
         @(posedge clk);
         #1;
         if (sb.size() == 0) begin
            n_checks++;
            $display("FAIL scoreboard_empty vec%0d: got no entry, want one", base + i);
         end else begin
            e = sb.pop_front();
            check($sformatf("vec%0d_dut%0d", e.idx, e.sel), outs(e.sel), e.exp);
         end
      end
      base += vecs.size();
      load = 1'b0; start = 1'b0; pause = 1'b0; tick = 1'b0;
      vecs.delete();
   endtask

   initial begin
      reset = 1'b1; tick = 1'b0; load = 1'b0; start = 1'b0; pause = 1'b0;
      load_min_tens = 3'd0; load_min_units = 4'd0;
      load_sec_tens = 3'd0; load_sec_units = 4'd0;
      #2 reset = 1'b0;
      #1;
      check("reset_dut0", outs(1'b0), 17'd0);
      check("reset_dut1", outs(1'b1), 17'd0);
      @(posedge clk);
      #1 reset = 1'b1;

      //   sel ld  lmt lmu lst lsu  st pa tk   mt mu st su  run exp dp
      add(0, 1,  0, 1, 0, 0,   0, 0, 0,   0, 1, 0, 0,  0, 0, 0);  // load 01:00
      add(0, 0,  0, 0, 0, 0,   1, 0, 0,   0, 1, 0, 0,  1, 0, 0);
      add(0, 0,  0, 0, 0, 0,   0, 0, 1,   0, 0, 5, 9,  1, 0, 0);
      add(0, 0,  0, 0, 0, 0,   0, 1, 0,   0, 0, 5, 9,  0, 0, 0);
      add(0, 1,  0, 0, 0, 2,   0, 0, 0,   0, 0, 0, 2,  0, 0, 0);  // load 00:02
      add(0, 0,  0, 0, 0, 0,   1, 0, 0,   0, 0, 0, 2,  1, 0, 0);
      add(0, 0,  0, 0, 0, 0,   0, 0, 1,   0, 0, 0, 1,  1, 0, 0);
      add(0, 0,  0, 0, 0, 0,   0, 0, 1,   0, 0, 0, 0,  0, 1, 1);  // expiry
      add(0, 0,  0, 0, 0, 0,   0, 0, 0,   0, 0, 0, 0,  0, 1, 0);
      add(0, 0,  0, 0, 0, 0,   0, 0, 1,   0, 0, 0, 0,  0, 1, 0);
      add(0, 0,  0, 0, 0, 0,   1, 0, 0,   0, 0, 0, 0,  0, 1, 0);  // start ignored
      add(0, 1,  1, 0, 0, 0,   0, 0, 0,   1, 0, 0, 0,  0, 0, 0);  // load 10:00
      add(0, 0,  0, 0, 0, 0,   1, 0, 0,   1, 0, 0, 0,  1, 0, 0);
      add(0, 0,  0, 0, 0, 0,   0, 0, 1,   0, 9, 5, 9,  1, 0, 0);  // full borrow
      add(0, 0,  0, 0, 0, 0,   0, 1, 0,   0, 9, 5, 9,  0, 0, 0);
      add(0, 1,  0, 0, 0, 5,   0, 0, 0,   0, 0, 0, 5,  0, 0, 0);  // load 00:05
      add(0, 0,  0, 0, 0, 0,   1, 0, 0,   0, 0, 0, 5,  1, 0, 0);
      add(0, 0,  0, 0, 0, 0,   0, 0, 1,   0, 0, 0, 4,  1, 0, 0);
      add(0, 0,  0, 0, 0, 0,   0, 0, 1,   0, 0, 0, 3,  1, 0, 0);
      add(0, 0,  0, 0, 0, 0,   0, 1, 1,   0, 0, 0, 3,  0, 0, 0);  // pause+tick
      add(0, 0,  0, 0, 0, 0,   0, 0, 1,   0, 0, 0, 3,  0, 0, 0);
      add(0, 0,  0, 0, 0, 0,   0, 0, 1,   0, 0, 0, 3,  0, 0, 0);
      add(0, 0,  0, 0, 0, 0,   0, 0, 1,   0, 0, 0, 3,  0, 0, 0);
      add(0, 0,  0, 0, 0, 0,   1, 0, 1,   0, 0, 0, 3,  1, 0, 0);  // start+tick
      add(0, 0,  0, 0, 0, 0,   0, 0, 1,   0, 0, 0, 2,  1, 0, 0);
      add(0, 0,  0, 0, 0, 0,   0, 1, 0,   0, 0, 0, 2,  0, 0, 0);
      add(0, 1,  7, 3, 2, 12,  0, 0, 0,   5, 3, 2, 9,  0, 0, 0);  // clamp
      add(0, 0,  0, 0, 0, 0,   1, 0, 0,   5, 3, 2, 9,  1, 0, 0);
      add(0, 1,  1, 1, 1, 1,   0, 0, 0,   5, 3, 2, 9,  1, 0, 0);  // load in RUN
      add(0, 0,  0, 0, 0, 0,   0, 0, 1,   5, 3, 2, 8,  1, 0, 0);
      add(0, 0,  0, 0, 0, 0,   0, 1, 0,   5, 3, 2, 8,  0, 0, 0);
      add(0, 1,  6, 15, 7, 3,  0, 0, 0,   5, 9, 5, 3,  0, 0, 0);  // clamp
      add(0, 1,  0, 0, 0, 0,   0, 0, 0,   0, 0, 0, 0,  0, 0, 0);  // load 00:00
      add(0, 0,  0, 0, 0, 0,   1, 0, 0,   0, 0, 0, 0,  0, 1, 1);  // start at zero
      add(0, 0,  0, 0, 0, 0,   0, 0, 0,   0, 0, 0, 0,  0, 1, 0);
      run_vecs();

      reset = 1'b0;
      #1;
      check("reset2_dut0", outs(1'b0), 17'd0);
      check("reset2_dut1", outs(1'b1), 17'd0);
      #2 reset = 1'b1;
      @(posedge clk);
      #1;

      add(1, 1,  0, 0, 0, 1,   0, 0, 0,   0, 0, 0, 1,  0, 0, 0);  // load 00:01
      add(1, 0,  0, 0, 0, 0,   1, 0, 0,   0, 0, 0, 1,  1, 0, 0);
      add(1, 0,  0, 0, 0, 0,   0, 0, 1,   0, 0, 0, 0,  1, 0, 1);  // expiry, stay RUN
      add(1, 0,  0, 0, 0, 0,   0, 0, 0,   0, 0, 0, 0,  1, 0, 0);
      add(1, 0,  0, 0, 0, 0,   0, 0, 1,   0, 0, 0, 1,  1, 0, 0);  // reload
      add(1, 0,  0, 0, 0, 0,   0, 0, 1,   0, 0, 0, 0,  1, 0, 1);
      add(1, 0,  0, 0, 0, 0,   0, 0, 1,   0, 0, 0, 1,  1, 0, 0);
      run_vecs();

      #3 reset = 1'b0;
      #1;
      check("midreset_dut0", outs(1'b0), 17'd0);
      check("midreset_dut1", outs(1'b1), 17'd0);
      #2 reset = 1'b1;
      @(posedge clk);
      #1;

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/countdown_timer.md
Name: countdown_timer

Overview:
- Loadable MM:SS countdown timer, 59:59 down to 00:00. It is the down-counting counterpart of the team's up-counting hour timer.
- Output digits use the same encoding: tens are 3-bit and range 0-5; units are 4-bit BCD and range 0-9.
- Decrements once per accepted tick and flags expiry. Sits beside the hour timer in the demo top, which supplies the 1 Hz tick and drives the 7-segment display.

Parameters:
- AUTO_RELOAD, 0, when 1 the timer reloads the last loaded value on expiry and keeps running.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-low reset.
- tick  input  1  one-cycle decrement enable (1 Hz strobe).
- load  input  1  load request; captures the load_* digits.
- load_min_tens  input  3  preset minutes tens.
- load_min_units  input  4  preset minutes units.
- load_sec_tens  input  3  preset seconds tens.
- load_sec_units  input  4  preset seconds units.
- start  input  1  start or resume counting.
- pause  input  1  suspend counting.
- min_tens  output  3  current minutes tens.
- min_units  output  4  current minutes units.
- sec_tens  output  3  current seconds tens.
- sec_units  output  4  current seconds units.
- running  output  1  high while in RUN.
- expired  output  1  level; high while in DONE.
- done_pulse  output  1  one-cycle strobe on each expiry.

Behaviour:
- Reset (reset=0, asynchronous): all digits and the stored preset go to 0; state IDLE; running, expired and done_pulse are 0.
- States:
  - IDLE: start -> RUN if the count is nonzero; start with the count at 00:00 -> DONE with done_pulse.
  - RUN: pause -> PAUSE; a tick decrements the count.
  - PAUSE: start -> RUN; the count holds.
  - DONE: the count holds at 00:00; start is ignored.
- Control priority per cycle: load > pause > start > tick.
- load is accepted in IDLE, PAUSE and DONE, and is ignored in RUN.
  - Digits and preset register update on the next edge; state goes to IDLE; expired clears.
- Load clamping: tens values > 5 clamp to 5; units values > 9 clamp to 9.
- Decrement (RUN and tick=1): one-cycle latency, new value visible the edge after tick.
  - sec_units decrements; 0 wraps to 9 with a borrow into sec_tens.
  - sec_tens wraps 0 to 5 with a borrow into min_units.
  - min_units wraps 0 to 9 with a borrow into min_tens.
  - min_tens decrements only on a borrow and never wraps below 0.
- Expiry: a tick that makes the count 00:00 produces, on the same edge:
  - AUTO_RELOAD=0: state DONE, expired=1, done_pulse=1 for exactly one cycle.
  - AUTO_RELOAD=1: the count shows 00:00 for one tick period and done_pulse=1. The next tick reloads the preset, with no decrement on that tick. The state stays RUN. If the preset is 00:00, the state goes to DONE instead.
- tick coinciding with pause in RUN: the tick is discarded and the count is unchanged.
- tick coinciding with start in IDLE or PAUSE: no decrement in that cycle.
- running is registered and equals (state==RUN).
- Reset asserted mid-count clears everything immediately, without waiting for a clock edge.

Decomposition:
- Package countdown_pkg:
  - typedef enum logic [1:0] {IDLE, RUN, PAUSE, DONE} cd_state_t
  - constants UNITS_MAX=9 and TENS_MAX=5.
- Sub-module down_digit, parameterized by width and MAX:
  - inputs: clk, reset, load, load_val, dec.
  - outputs: q, borrow_out (= dec && q==0).
  - Instantiated four times and chained by borrow_out -> dec.

Test Plan:
- Load 01:00, start, apply 1 tick -> count 00:59, running=1.
- Load 00:02, start, apply 2 ticks -> count 00:00, then expired=1 and done_pulse high for exactly 1 cycle; a further tick leaves 00:00.
- Load 10:00, start, apply 1 tick -> count 09:59, a full borrow chain.
- Load 00:05, start, 2 ticks, pause together with a tick, 3 more ticks -> count holds at 00:03; then start and 1 tick -> 00:02.
- Load with min_tens=7 and sec_units=12 -> count reads 5?:?9 with both out-of-range digits clamped; a load asserted during RUN is ignored.
- AUTO_RELOAD=1, load 00:01, start, 1 tick -> 00:00 with done_pulse; next tick -> 00:01, state still RUN. In a separate run, drive reset low mid-count -> all outputs 0 immediately.
